uart_rx_deframer: RTL and testbench

//  UART receive deframer with a run-time programmable bit period. Samples the asynchronous RX line,

---
 rtl/uart_rx_deframer_if.sv | 13 +
 rtl/uart_rx_deframer.sv | 153 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// Signal bundle between the serial line / byte consumer and the UART receive deframer.
// master = line driver and consumer side, slave = deframer side.
interface uart_rx_deframer_if;
  logic        RX;
  logic [15:0] baud_cnt;
  logic        clr_rdy;
  logic [7:0]  rx_data;
  logic        rdy;
  logic        frame_err;

  modport master (output RX, baud_cnt, clr_rdy, input rx_data, rdy, frame_err);
  modport slave  (input RX, baud_cnt, clr_rdy, output rx_data, rdy, frame_err);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer with a run-time bit period and a sticky rdy flag.
// Optional stop-bit checking is enabled by defining UART_RX_FRAME_CHK_EN.
module uart_rx_deframer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_deframer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rx_sync;
  logic [15:0]            timer_q, timer_d;
  logic [15:0]            bit_per_q, bit_per_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rdy_q, rdy_d;
  logic                   set_rdy_q, set_rdy_d;
`ifdef UART_RX_FRAME_CHK_EN
  logic                   ferr_pend_q, ferr_pend_d;
  logic                   frame_err_q, frame_err_d;
`endif

  assign rx_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_per_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rdy_q       <= 1'b0;
      set_rdy_q   <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
      ferr_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.RX};
      prev_q      <= rx_sync;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_per_q   <= bit_per_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      set_rdy_q   <= set_rdy_d;
`ifdef UART_RX_FRAME_CHK_EN
      ferr_pend_q <= ferr_pend_d;
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_per_d   = bit_per_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    set_rdy_d   = 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
    ferr_pend_d = 1'b0;
    frame_err_d = ferr_pend_q;
`endif

    if (bus.clr_rdy) begin
      rdy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (prev_q && !rx_sync) begin
          bit_per_d = bus.baud_cnt;
          timer_d   = bus.baud_cnt >> 1;
          bit_idx_d = 4'd0;
          rdy_d     = 1'b0;
          state_d   = RECV;
        end
      end
      RECV: begin
        // Half-period initial load plus full-period reloads puts every sample mid-bit.
        if (timer_q == 16'd0) begin
          timer_d   = bit_per_q - 16'd1;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd0) begin
            if (rx_sync) begin
              bit_idx_d = 4'd0;
              state_d   = IDLE;
            end
          end else if (bit_idx_q <= 4'd8) begin
            shift_d = {rx_sync, shift_q[7:1]};
          end else begin
            bit_idx_d = 4'd0;
            state_d   = IDLE;
`ifdef UART_RX_FRAME_CHK_EN
            if (rx_sync) begin
              rx_data_d = shift_q;
              set_rdy_d = 1'b1;
            end else begin
              ferr_pend_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
`else
            rx_data_d = shift_q;
            set_rdy_d = 1'b1;
`endif
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame completion outranks both clr_rdy and a fresh start detection.
    if (set_rdy_q) begin
      rdy_d = 1'b1;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
`ifdef UART_RX_FRAME_CHK_EN
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: randomized 8N1 frames checked against a
// behavioural model of expected bytes and arrival windows.
module tb_uart_rx_deframer;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  int         total;
  int         bad;
  logic [7:0] last_byte;

  uart_rx_deframer_if bus ();

  uart_rx_deframer #(.SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks from the start-bit falling edge to rdy, from the line timing alone.
  function automatic int expected_latency(input int b);
    return SYNC + 1 + (b / 2) + 9 * b + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int b, input logic stop);
    bus.RX = 1'b0;
    tick(b);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      tick(b);
    end
    bus.RX = stop;
    tick(b);
    bus.RX = 1'b1;
  endtask

  task automatic wait_rdy(input int budget, output int n);
    n = 0;
    while (bus.rdy !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic clear_rdy();
    bus.clr_rdy = 1'b1;
    tick(1);
    bus.clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.RX       = 1'b1;
    bus.clr_rdy  = 1'b0;
    bus.baud_cnt = 16'd16;
    tick(3);
    total++;
    if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy got=%b expected=0", bus.rdy); end
    total++;
    if (bus.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h expected=00", bus.rx_data); end
    total++;
    if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr got=%b expected=0", bus.frame_err); end
    rst_n = 1'b1;
    tick(4);
    total++;
    if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_rdy got=%b expected=0", bus.rdy); end
    last_byte = 8'h00;
  endtask

  task automatic test_false_start();
    int highs;
    highs = 0;
    bus.baud_cnt = 16'd16;
    bus.RX = 1'b0;
    tick(5);
    bus.RX = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (bus.rdy === 1'b1) highs++;
    end
    total++;
    if (highs !== 0) begin bad++; $display("[TB] FAIL false_start_rdy got=%0d rdy cycles expected=0", highs); end
    total++;
    if (bus.rx_data !== last_byte) begin bad++; $display("[TB] FAIL false_start_data got=%h expected=%h", bus.rx_data, last_byte); end
  endtask

  task automatic test_single();
    int n, lat, drops, b;
    logic [7:0] d;
    b = 434;
    d = 8'hA5;
    bus.baud_cnt = 16'(b);
    clear_rdy();
    fork
      send_frame(d, b, 1'b1);
      wait_rdy(12 * b, n);
    join
    lat = expected_latency(b);
    total++;
    if (n < lat - 1 || n > lat + 1) begin bad++; $display("[TB] FAIL latency_434 got=%0d expected=%0d+/-1", n, lat); end
    total++;
    if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL data_434 got=%h expected=%h", bus.rx_data, d); end
    last_byte = d;
    drops = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.rdy !== 1'b1) drops++;
    end
    total++;
    if (drops !== 0) begin bad++; $display("[TB] FAIL rdy_sticky got=%0d low cycles expected=0", drops); end
    clear_rdy();
    total++;
    if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL clr_rdy got=%b expected=0", bus.rdy); end
  endtask

  task automatic test_random();
    int n, lat, b;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      b = int'($urandom_range(16, 48));
      d = 8'($urandom);
      bus.baud_cnt = 16'(b);
      clear_rdy();
      fork
        send_frame(d, b, 1'b1);
        wait_rdy(12 * b, n);
      join
      lat = expected_latency(b);
      total++;
      if (n < lat - 1 || n > lat + 1) begin bad++; $display("[TB] FAIL latency_rand b=%0d got=%0d expected=%0d+/-1", b, n, lat); end
      total++;
      if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL data_rand b=%0d got=%h expected=%h", b, bus.rx_data, d); end
      last_byte = d;
      tick(3);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] g;
    int cyc, budget;
    exp_q = '{8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
    bus.baud_cnt = 16'd16;
    budget = exp_q.size() * 10 * 16 + 100;
    clear_rdy();
    fork
      begin
        foreach (exp_q[i]) send_frame(exp_q[i], 16, 1'b1);
      end
      begin
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < budget) begin
          if (bus.rdy === 1'b1) begin
            got_q.push_back(bus.rx_data);
            bus.clr_rdy = 1'b1;
            tick(1);
            bus.clr_rdy = 1'b0;
          end else begin
            tick(1);
          end
          cyc++;
        end
      end
    join
    total++;
    if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL b2b_count got=%0d expected=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      total++;
      if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%h expected=%h", i, g, exp_q[i]); end
    end
    last_byte = exp_q[exp_q.size() - 1];
    tick(3);
  endtask

  task automatic test_set_wins();
    int highs;
    logic [7:0] d;
    d = 8'($urandom);
    bus.baud_cnt = 16'd16;
    clear_rdy();
    bus.clr_rdy = 1'b1;
    highs = 0;
    fork
      send_frame(d, 16, 1'b1);
      for (int i = 0; i < 12 * 16; i++) begin
        tick(1);
        if (bus.rdy === 1'b1) highs++;
      end
    join
    bus.clr_rdy = 1'b0;
    total++;
    if (highs !== 1) begin bad++; $display("[TB] FAIL set_wins got=%0d rdy cycles expected=1", highs); end
    total++;
    if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL set_wins_data got=%h expected=%h", bus.rx_data, d); end
    last_byte = d;
  endtask

  task automatic test_midframe_reset();
    int n, lat, highs;
    logic [7:0] d;
    d = 8'h3C;
    bus.baud_cnt = 16'd16;
    clear_rdy();
    highs = 0;
    bus.RX = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      bus.RX = d[i];
      tick(16);
    end
    bus.RX = d[4];
    tick(8);
    rst_n  = 1'b0;
    bus.RX = 1'b1;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (bus.rdy === 1'b1) highs++;
    end
    last_byte = 8'h00;
    total++;
    if (highs !== 0) begin bad++; $display("[TB] FAIL midreset_rdy got=%0d rdy cycles expected=0", highs); end
    total++;
    if (bus.rx_data !== last_byte) begin bad++; $display("[TB] FAIL midreset_data got=%h expected=%h", bus.rx_data, last_byte); end
    d = 8'h81;
    fork
      send_frame(d, 16, 1'b1);
      wait_rdy(12 * 16, n);
    join
    lat = expected_latency(16);
    total++;
    if (n < lat - 1 || n > lat + 1) begin bad++; $display("[TB] FAIL midreset_latency got=%0d expected=%0d+/-1", n, lat); end
    total++;
    if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL midreset_new_data got=%h expected=%h", bus.rx_data, d); end
    last_byte = d;
    clear_rdy();
    tick(40);
    total++;
    if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_extra_rdy got=%b expected=0", bus.rdy); end
  endtask

  task automatic test_baud_change();
    int n, lat;
    logic [7:0] d;
    d = 8'h5A;
    bus.baud_cnt = 16'd16;
    clear_rdy();
    fork
      send_frame(d, 16, 1'b1);
      wait_rdy(12 * 16, n);
      begin
        tick(48);
        bus.baud_cnt = 16'd32;
      end
    join
    lat = expected_latency(16);
    total++;
    if (n < lat - 1 || n > lat + 1) begin bad++; $display("[TB] FAIL baudchg_latency16 got=%0d expected=%0d+/-1", n, lat); end
    total++;
    if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL baudchg_data16 got=%h expected=%h", bus.rx_data, d); end
    last_byte = d;
    d = 8'($urandom);
    clear_rdy();
    fork
      send_frame(d, 32, 1'b1);
      wait_rdy(12 * 32, n);
    join
    lat = expected_latency(32);
    total++;
    if (n < lat - 1 || n > lat + 1) begin bad++; $display("[TB] FAIL baudchg_latency32 got=%0d expected=%0d+/-1", n, lat); end
    total++;
    if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL baudchg_data32 got=%h expected=%h", bus.rx_data, d); end
    last_byte = d;
  endtask

  task automatic test_frame_err();
    int ferr_cycles, rdy_cycles, n;
    logic [7:0] d;
    logic [7:0] prev;
    d    = 8'h77;
    prev = last_byte;
    bus.baud_cnt = 16'd16;
    clear_rdy();
    ferr_cycles = 0;
    rdy_cycles  = 0;
    fork
      send_frame(d, 16, 1'b0);
      for (int i = 0; i < 12 * 16; i++) begin
        tick(1);
        if (bus.frame_err === 1'b1) ferr_cycles++;
        if (bus.rdy === 1'b1) rdy_cycles++;
      end
    join
`ifdef UART_RX_FRAME_CHK_EN
    total++;
    if (ferr_cycles !== 1) begin bad++; $display("[TB] FAIL ferr_pulse got=%0d cycles expected=1", ferr_cycles); end
    total++;
    if (rdy_cycles !== 0) begin bad++; $display("[TB] FAIL ferr_rdy got=%0d cycles expected=0", rdy_cycles); end
    total++;
    if (bus.rx_data !== prev) begin bad++; $display("[TB] FAIL ferr_data got=%h expected=%h", bus.rx_data, prev); end
`else
    total++;
    if (ferr_cycles !== 0) begin bad++; $display("[TB] FAIL ferr_tied got=%0d cycles expected=0", ferr_cycles); end
    total++;
    if (bus.rdy !== 1'b1) begin bad++; $display("[TB] FAIL nochk_rdy got=%b expected=1", bus.rdy); end
    total++;
    if (bus.rx_data !== d) begin bad++; $display("[TB] FAIL nochk_data got=%h expected=%h (prev %h)", bus.rx_data, d, prev); end
    last_byte = d;
`endif
    tick(32);
    d = 8'($urandom);
    clear_rdy();
    fork
      send_frame(d, 16, 1'b1);
      wait_rdy(12 * 16, n);
    join
    total++;
    if (bus.rdy !== 1'b1 || bus.rx_data !== d) begin
      bad++;
      $display("[TB] FAIL recover rdy=%b data got=%h expected rdy=1 data=%h", bus.rdy, bus.rx_data, d);
    end
    last_byte = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_false_start();
    test_single();
    test_random();
    test_back_to_back();
    test_set_wins();
    test_midframe_reset();
    test_baud_change();
    test_frame_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=timeout expected=completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
